// File: rtl/pe_combine.sv
// pe_combine
//   Combines FILTER_SIZE signed partial sums per output pixel into a
//   membrane potential. When the potential reaches THRESHOLD it emits a
//   spike packet. A per-pixel residual carries leftover potential from one
//   pixel completion (timestep) to the next.
//
// Ports
//   clk         single clock, rising edge
//   reset       asynchronous, active-high
//   in_data     [29:26] dest, [25] opcode, [24:16] index, [15:14] reserved,
//               [13:0] signed partial sum
//   in_valid    in_data is valid
//   in_ready    block accepts in_data this cycle (IDLE only)
//   out_data    [29:26] DEST_ADDR, [25] 1, [24:16] index, [15:1] 0, [0] spike
//   out_valid   out_data is valid
//   out_ready   downstream accepts out_data this cycle
//   drop_count  saturating count of discarded input packets
module pe_combine #(
  parameter int         FILTER_SIZE = 5,
  parameter int         IFMAP_SIZE  = 25,
  parameter int         THRESHOLD   = 64,
  parameter logic [3:0] MY_ADDR     = 4'd5,
  parameter logic [3:0] DEST_ADDR   = 4'd6
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [29:0] in_data,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [29:0] out_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [7:0]  drop_count
);

  localparam int NUM_OUTPUTS = (IFMAP_SIZE - FILTER_SIZE + 1) * (IFMAP_SIZE - FILTER_SIZE + 1);
  localparam int IDX_W       = 9;
  localparam int CNT_W       = $clog2(FILTER_SIZE + 1);
  localparam int PSUM_W      = 14;
  localparam int ACC_W       = 17;
  localparam int POT_W       = 18;

  localparam logic [IDX_W-1:0]        LAST_IDX = IDX_W'(NUM_OUTPUTS - 1);
  localparam logic [CNT_W-1:0]        CNT_LAST = CNT_W'(FILTER_SIZE - 1);
  localparam logic signed [POT_W-1:0] THR_S    = POT_W'(THRESHOLD);

  typedef enum logic [2:0] {
    S_INIT  = 3'd0,
    S_IDLE  = 3'd1,
    S_ACCUM = 3'd2,
    S_FIRE  = 3'd3,
    S_SEND  = 3'd4
  } state_t;

  // Clamp a 19-bit intermediate potential into the 18-bit signed range.
  function automatic logic signed [POT_W-1:0] sat_pot(input logic signed [POT_W:0] x);
    if (x[POT_W] != x[POT_W-1]) begin
      return x[POT_W] ? {1'b1, {(POT_W-1){1'b0}}} : {1'b0, {(POT_W-1){1'b1}}};
    end
    return x[POT_W-1:0];
  endfunction

  // Per-pixel state; cleared by the INIT sweep rather than by reset.
  logic signed [ACC_W-1:0] acc_mem [NUM_OUTPUTS];
  logic        [CNT_W-1:0] cnt_mem [NUM_OUTPUTS];
  logic signed [POT_W-1:0] res_mem [NUM_OUTPUTS];

  state_t                  state_q, state_d;
  logic [IDX_W-1:0]        init_idx_q, init_idx_d;
  logic [7:0]              drop_cnt_q, drop_cnt_d;
  logic                    out_valid_q, out_valid_d;
  logic [29:0]             out_data_q, out_data_d;
  logic [IDX_W-1:0]        pkt_idx_q, pkt_idx_d;
  logic signed [PSUM_W-1:0] psum_q, psum_d;
  logic signed [ACC_W-1:0] sum_q, sum_d;

  // Input packet fields
  logic [3:0]       in_dest;
  logic             in_op;
  logic [IDX_W-1:0] in_idx;
  logic             pkt_ok;
  logic             accepted;
  logic             unused_rsv;

  assign in_dest    = in_data[29:26];
  assign in_op      = in_data[25];
  assign in_idx     = in_data[24:16];
  assign unused_rsv = ^in_data[15:14];
  assign pkt_ok     = (in_dest == MY_ADDR) && !in_op && (in_idx <= LAST_IDX);

  // Datapath values
  logic signed [ACC_W-1:0] acc_rd;
  logic        [CNT_W-1:0] cnt_rd;
  logic signed [POT_W-1:0] res_rd;
  logic signed [ACC_W-1:0] sum_now;
  logic                    last_psum;
  logic signed [POT_W:0]   pot_wide;
  logic signed [POT_W-1:0] pot;
  logic                    spike;
  logic signed [POT_W-1:0] res_new;

  assign acc_rd    = acc_mem[pkt_idx_q];
  assign cnt_rd    = cnt_mem[pkt_idx_q];
  assign res_rd    = res_mem[pkt_idx_q];
  assign sum_now   = acc_rd + {{(ACC_W-PSUM_W){psum_q[PSUM_W-1]}}, psum_q};
  assign last_psum = (cnt_rd >= CNT_LAST);
  assign pot_wide  = {{(POT_W+1-ACC_W){sum_q[ACC_W-1]}}, sum_q} + {res_rd[POT_W-1], res_rd};
  assign pot       = sat_pot(pot_wide);
  assign spike     = (pot >= THR_S);
  // A spike only happens with pot >= THRESHOLD, so the subtraction cannot wrap.
  assign res_new   = spike ? (pot - THR_S) : pot;

  // Memory write port controls
  logic                    mem_we;
  logic                    res_we;
  logic [IDX_W-1:0]        wr_idx;
  logic signed [ACC_W-1:0] wr_acc;
  logic        [CNT_W-1:0] wr_cnt;
  logic signed [POT_W-1:0] wr_res;

  // ---------------------------------------------------------------- FSM
  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_INIT;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_INIT:  if (init_idx_q == LAST_IDX) state_d = S_IDLE;
      S_IDLE:  if (in_valid && pkt_ok) state_d = S_ACCUM;
      S_ACCUM: state_d = last_psum ? S_FIRE : S_IDLE;
      S_FIRE:  state_d = S_SEND;
      S_SEND:  if (out_ready) state_d = S_IDLE;
      default: state_d = S_INIT;
    endcase
  end

  // State-decoded outputs: handshake and memory write port
  always_comb begin
    in_ready = 1'b0;
    mem_we   = 1'b0;
    res_we   = 1'b0;
    wr_idx   = pkt_idx_q;
    wr_acc   = '0;
    wr_cnt   = '0;
    wr_res   = '0;
    case (state_q)
      S_INIT: begin
        mem_we = 1'b1;
        res_we = 1'b1;
        wr_idx = init_idx_q;
      end
      S_IDLE: in_ready = 1'b1;
      S_ACCUM: begin
        if (!last_psum) begin
          mem_we = 1'b1;
          wr_acc = sum_now;
          wr_cnt = cnt_rd + 1'b1;
        end
      end
      S_FIRE: begin
        mem_we = 1'b1;
        res_we = 1'b1;
        wr_res = res_new;
      end
      default: ;
    endcase
  end

  // ---------------------------------------------------------------- control regs
  assign accepted = in_valid && in_ready;

  always_comb begin
    init_idx_d  = init_idx_q;
    drop_cnt_d  = drop_cnt_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    if (state_q == S_INIT) begin
      init_idx_d = (init_idx_q == LAST_IDX) ? '0 : init_idx_q + 1'b1;
    end
    if (accepted && !pkt_ok && (drop_cnt_q != 8'hFF)) begin
      drop_cnt_d = drop_cnt_q + 8'd1;
    end
    if (state_q == S_FIRE) begin
      out_valid_d = 1'b1;
      out_data_d  = {DEST_ADDR, 1'b1, pkt_idx_q, 15'd0, spike};
    end else if ((state_q == S_SEND) && out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      init_idx_q  <= '0;
      drop_cnt_q  <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      init_idx_q  <= init_idx_d;
      drop_cnt_q  <= drop_cnt_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
    end
  end

  // ---------------------------------------------------------------- data regs
  always_comb begin
    pkt_idx_d = pkt_idx_q;
    psum_d    = psum_q;
    sum_d     = sum_q;
    if (accepted && pkt_ok) begin
      pkt_idx_d = in_idx;
      psum_d    = $signed(in_data[PSUM_W-1:0]);
    end
    if (state_q == S_ACCUM) begin
      sum_d = sum_now;
    end
  end

  always_ff @(posedge clk) begin
    pkt_idx_q <= pkt_idx_d;
    psum_q    <= psum_d;
    sum_q     <= sum_d;
  end

  // ---------------------------------------------------------------- memories
  always_ff @(posedge clk) begin
    if (mem_we) begin
      acc_mem[wr_idx] <= wr_acc;
      cnt_mem[wr_idx] <= wr_cnt;
    end
    if (res_we) begin
      res_mem[wr_idx] <= wr_res;
    end
  end

  assign out_valid  = out_valid_q;
  assign out_data   = out_data_q;
  assign drop_count = drop_cnt_q;

endmodule
